pkt_seq: RTL and testbench
==========================

# pkt_seq

Transmit packet sequencer between the AXI slave write-data path (per-VC TX buffers) and the packet processor. It takes a stream of flit-data beats and tracks packet boundaries with a flit down-counter. It tags each beat as new/body/last, locks the VC for the whole packet, and presents a registered `s_pkt_out_req_t` to the packet processor. A skid stage decouples the upstream ready path from the NoC local input buffer.

## Interface
Parameters:
- `AUTO_SZ`, default `` `AUTO_ADD_PKT_SZ ``: packet size source.
  - 1: size comes from `pkt_sz_i`, sampled on the head beat.
  - 0: size comes from head beat bits `[PktPosWidth-1 : PktPosWidth-PktWidth]`.

Ports:
- `clk_axi`  in  1  clock; one clock for the whole block.
- `arst_axi`  in  1  reset; synchronous, active-high.
- `beat_valid_i`  in  1  upstream beat valid.
- `beat_data_i`  in  `FlitDataWidth`  flit payload.
- `beat_vc_i`  in  `$clog2(NumVirtChn)`  VC of the beat; used on head beats only.
- `pkt_sz_i`  in  `PktWidth`  packet length in flits; used when `AUTO_SZ=1`, on head beats only.
- `beat_ready_o`  out  1  upstream beat ready.
- `pkt_out_req_o`  out  `s_pkt_out_req_t`  request to the packet processor, with fields valid / req_new / req_last / flit_data_width / pkt_sz / vc_id.
- `pkt_out_resp_i`  in  `s_pkt_out_resp_t`  `.ready` from the packet processor.
- `busy_o`  out  1  high while a packet is open (head accepted, tail not yet accepted from upstream).
- `pkt_done_o`  out  1  one-cycle pulse, the cycle after a `req_last` flit handshakes downstream.

## Operation
- Accept = `beat_valid_i & beat_ready_o`. Downstream handshake = `pkt_out_req_o.valid & pkt_out_resp_i.ready`.
- FSM states: `IDLE`, `PAYLOAD`.
- `IDLE`, accepted beat = head:
  - sz = selected source; sz==0 is treated as 1.
  - Latch `vc_q = beat_vc_i` and `sz_q = sz`; load `rem = sz-1`.
  - Emit flit: req_new=1, req_last=(sz==1), pkt_sz=sz, vc_id=beat_vc_i.
  - Go to `PAYLOAD` if sz>1; otherwise stay in `IDLE`.
- `PAYLOAD`, accepted beat:
  - Emit req_new=0, req_last=(rem==1), vc_id=`vc_q`, pkt_sz=`sz_q`. `beat_vc_i` and `pkt_sz_i` are ignored.
  - `rem` decrements. Return to `IDLE` when rem==1 at accept.
- `rem` is `PktWidth` bits and never wraps: it decrements only in `PAYLOAD`, where rem≥1.
- Maximum packet length is 2^PktWidth-1 flits.
- `busy_o` = (state==`PAYLOAD`).

## Timing
- Output stage is a 2-entry skid buffer (main + skid register).
  - Latency: a beat accepted at cycle N is on `pkt_out_req_o` at N+1.
  - Throughput: 1 flit/cycle while `pkt_out_resp_i.ready` is high.
- `beat_ready_o` = !skid_valid, a registered signal with no combinational path from `pkt_out_resp_i`.
- Downstream ready low with main full:
  - The next accepted beat goes to skid, then `beat_ready_o` drops.
  - On the next downstream handshake, skid moves to main and `beat_ready_o` rises the following cycle.
- Once `pkt_out_req_o.valid` is high, all fields are held stable until the handshake. Valid never drops without a handshake (except on reset).
- Flit order is preserved exactly. Counter/FSM update on upstream accept, not on downstream handshake.
- Reset values:
  - `pkt_out_req_o` = '0 (valid=0).
  - `beat_ready_o`=1, `busy_o`=0, `pkt_done_o`=0.
  - FSM `IDLE`, rem=0, both skid entries invalid.
- Reset mid-packet drops the open packet and any buffered flits with no tail emitted. The router on the same reset is required to be cleared too.
- A tail accept and a following head on the next cycle are back-to-back with no bubble.

## Structure
- Shared, in `ravenoc_pkg`:
  - `pkt_seq_st_t` enum {IDLE, PAYLOAD}.
  - Existing `s_pkt_out_req_t` / `s_pkt_out_resp_t`, `FlitDataWidth`, `PktWidth`, `PktPosWidth`, `NumVirtChn`.
- Sub-module: `skid_buffer #(.WIDTH)`, a generic valid/ready 2-entry register slice, instantiated once on the packed request.

## Test plan
- sz=4, vc=1, ready always 1, beats D0..D3 back-to-back → cycles 1..4 out: new/-/-/last, vc=1 on all, pkt_sz=4; `pkt_done_o` at cycle 5; `busy_o` high cycles 1..3.
- sz=1 single beat → one flit with req_new=1 and req_last=1; FSM stays `IDLE`; next head is accepted the following cycle.
- sz=3, vc=2, then `beat_vc_i` set to 0 on body beats → all 3 flits carry vc_id=2.
- Downstream ready low 5 cycles during a 6-flit packet → exactly 2 beats absorbed, then `beat_ready_o`=0. Output is stable and no flit is lost or duplicated after ready returns.
- `AUTO_SZ=0`, head data size field=0 → treated as 1-flit packet (req_last=1).
- Assert `arst_axi` after flit 2 of 5 → next cycle valid=0, `busy_o`=0, `beat_ready_o`=1; the next beat is treated as a head.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// Shared types and sizes for the NoC transmit path.
// Holds the packet request/response structs and the pkt_seq FSM encoding.
`ifndef AUTO_ADD_PKT_SZ
`define AUTO_ADD_PKT_SZ 1
`endif

package ravenoc_pkg;

    localparam int FlitDataWidth = 32;
    localparam int PktWidth      = 8;
    localparam int PktPosWidth   = 32;
    localparam int NumVirtChn    = 4;
    localparam int VcWidth       = $clog2(NumVirtChn);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } pkt_seq_st_t;

    typedef struct packed {
        logic                     valid;
        logic                     req_new;
        logic                     req_last;
        logic [FlitDataWidth-1:0] flit_data_width;
        logic [PktWidth-1:0]      pkt_sz;
        logic [VcWidth-1:0]       vc_id;
    } s_pkt_out_req_t;

    typedef struct packed {
        logic ready;
    } s_pkt_out_resp_t;

    // A zero length on a head beat still carries that beat, so it is a 1-flit packet.
    function automatic logic [PktWidth-1:0] norm_sz(input logic [PktWidth-1:0] raw);
        return (raw == '0) ? PktWidth'(1) : raw;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready register slice (main + skid register).
// Ports: in_* upstream side (in_ready_o is registered), out_* downstream side.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             push;
    logic             pop;

    always_comb begin
        push         = in_valid_i & ~skid_valid_q;
        pop          = main_valid_q & out_ready_i;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // Upstream is stalled; only draining skid into main can happen.
            if (pop) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!main_valid_q || pop) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end else if (pop) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/pkt_seq.sv
// Transmit packet sequencer: tags beats new/body/last, locks VC per packet.
// Ports: beat_* upstream stream, pkt_out_* to packet processor, busy_o / pkt_done_o status.
`ifndef AUTO_ADD_PKT_SZ
`define AUTO_ADD_PKT_SZ 1
`endif

module pkt_seq
    import ravenoc_pkg::*;
#(
    parameter int AUTO_SZ = `AUTO_ADD_PKT_SZ
) (
    input  logic                     clk_axi,
    input  logic                     arst_axi,
    input  logic                     beat_valid_i,
    input  logic [FlitDataWidth-1:0] beat_data_i,
    input  logic [VcWidth-1:0]       beat_vc_i,
    input  logic [PktWidth-1:0]      pkt_sz_i,
    output logic                     beat_ready_o,
    output s_pkt_out_req_t           pkt_out_req_o,
    input  s_pkt_out_resp_t          pkt_out_resp_i,
    output logic                     busy_o,
    output logic                     pkt_done_o
);

    localparam int ReqW = $bits(s_pkt_out_req_t);
    localparam logic [PktWidth-1:0] OneSz = PktWidth'(1);

    pkt_seq_st_t         state_q, state_d;
    logic [PktWidth-1:0] rem_q, rem_d;
    logic [PktWidth-1:0] sz_q, sz_d;
    logic [VcWidth-1:0]  vc_q, vc_d;
    logic                done_q, done_d;

    logic                accept;
    logic [PktWidth-1:0] head_sz;
    s_pkt_out_req_t      req_in;
    s_pkt_out_req_t      buf_req;
    logic [ReqW-1:0]     buf_data;
    logic                buf_valid;

    assign accept  = beat_valid_i & beat_ready_o;
    assign head_sz = norm_sz((AUTO_SZ != 0) ? pkt_sz_i
                                            : beat_data_i[PktPosWidth-1 -: PktWidth]);

    // State register
    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sz_q    <= '0;
            vc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sz_q    <= sz_d;
            vc_q    <= vc_d;
            done_q  <= done_d;
        end
    end

    // Next state: advances on upstream accept only
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sz_d    = sz_q;
        vc_d    = vc_q;
        done_d  = buf_valid & pkt_out_resp_i.ready & buf_req.req_last;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    vc_d  = beat_vc_i;
                    sz_d  = head_sz;
                    rem_d = head_sz - OneSz;
                    if (head_sz != OneSz) begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    rem_d = rem_q - OneSz;
                    if (rem_q == OneSz) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output: build the request word for the current beat
    always_comb begin
        req_in                 = '0;
        req_in.valid           = 1'b1;
        req_in.flit_data_width = beat_data_i;
        if (state_q == IDLE) begin
            req_in.req_new  = 1'b1;
            req_in.req_last = (head_sz == OneSz);
            req_in.pkt_sz   = head_sz;
            req_in.vc_id    = beat_vc_i;
        end else begin
            req_in.req_new  = 1'b0;
            req_in.req_last = (rem_q == OneSz);
            req_in.pkt_sz   = sz_q;
            req_in.vc_id    = vc_q;
        end
    end

    skid_buffer #(
        .WIDTH(ReqW)
    ) u_skid (
        .clk        (clk_axi),
        .rst        (arst_axi),
        .in_valid_i (beat_valid_i),
        .in_data_i  (req_in),
        .in_ready_o (beat_ready_o),
        .out_valid_o(buf_valid),
        .out_data_o (buf_data),
        .out_ready_i(pkt_out_resp_i.ready)
    );

    assign buf_req       = s_pkt_out_req_t'(buf_data);
    assign pkt_out_req_o = buf_valid ? buf_req : '0;
    assign busy_o        = (state_q == PAYLOAD);
    assign pkt_done_o    = done_q;

endmodule

// File: tb/tb_pkt_seq.sv
// Self-checking bench for pkt_seq: directed table, corner sequences, random vs packet model.
// Drives and samples on the falling edge; the DUT acts on the rising edge.
module tb_pkt_seq;
    import ravenoc_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    always #5 clk = ~clk;

    logic            v1 = 1'b0;
    logic [31:0]     d1 = '0;
    logic [1:0]      vc1 = '0;
    logic [7:0]      sz1 = '0;
    logic            brdy1;
    s_pkt_out_req_t  req1;
    s_pkt_out_resp_t resp1;
    logic            busy1, done1;

    logic            v0 = 1'b0;
    logic [31:0]     d0 = '0;
    logic [1:0]      vc0 = '0;
    logic [7:0]      sz0 = '0;
    logic            brdy0;
    s_pkt_out_req_t  req0;
    s_pkt_out_resp_t resp0;
    logic            busy0, done0;

    pkt_seq #(.AUTO_SZ(1)) dut1 (
        .clk_axi(clk), .arst_axi(rst),
        .beat_valid_i(v1), .beat_data_i(d1), .beat_vc_i(vc1), .pkt_sz_i(sz1),
        .beat_ready_o(brdy1), .pkt_out_req_o(req1), .pkt_out_resp_i(resp1),
        .busy_o(busy1), .pkt_done_o(done1)
    );

    pkt_seq #(.AUTO_SZ(0)) dut0 (
        .clk_axi(clk), .arst_axi(rst),
        .beat_valid_i(v0), .beat_data_i(d0), .beat_vc_i(vc0), .pkt_sz_i(sz0),
        .beat_ready_o(brdy0), .pkt_out_req_o(req0), .pkt_out_resp_i(resp0),
        .busy_o(busy0), .pkt_done_o(done0)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Packet-level reference: each packet expands into its expected flit list.
    typedef struct {
        logic        nw;
        logic        last;
        logic [1:0]  vc;
        logic [7:0]  sz;
        logic [31:0] data;
    } flit_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  vc;
        logic [7:0]  szf;
        flit_t       f;
    } beat_t;

    beat_t beats_q[$];
    flit_t out_q[$];
    bit    open_pkt = 0;
    bit    done_exp = 0;

    task automatic add_pkt(input int szf, input logic [1:0] vc);
        int    eff;
        beat_t b;
        eff = (szf == 0) ? 1 : szf;
        for (int i = 0; i < eff; i++) begin
            b.data   = $urandom;
            b.vc     = (i == 0) ? vc : 2'($urandom);
            b.szf    = (i == 0) ? 8'(szf) : 8'($urandom);
            b.f.nw   = (i == 0);
            b.f.last = (i == eff - 1);
            b.f.vc   = vc;
            b.f.sz   = 8'(eff);
            b.f.data = b.data;
            beats_q.push_back(b);
        end
    endtask

    task automatic step(input bit ven, input bit rdy);
        beat_t b;
        bit    acc, hs;
        chk("out_valid", 64'(req1.valid), 64'(out_q.size() > 0));
        if (out_q.size() > 0) begin
            chk("req_new", 64'(req1.req_new), 64'(out_q[0].nw));
            chk("req_last", 64'(req1.req_last), 64'(out_q[0].last));
            chk("vc_id", 64'(req1.vc_id), 64'(out_q[0].vc));
            chk("pkt_sz", 64'(req1.pkt_sz), 64'(out_q[0].sz));
            chk("data", 64'(req1.flit_data_width), 64'(out_q[0].data));
        end
        chk("beat_ready", 64'(brdy1), 64'(out_q.size() < 2));
        chk("busy", 64'(busy1), 64'(open_pkt));
        chk("pkt_done", 64'(done1), 64'(done_exp));
        v1 = ven && (beats_q.size() > 0);
        if (v1) begin
            d1  = beats_q[0].data;
            vc1 = beats_q[0].vc;
            sz1 = beats_q[0].szf;
        end
        resp1.ready = rdy;
        acc = v1 && (out_q.size() < 2);
        hs  = (out_q.size() > 0) && rdy;
        @(negedge clk);
        done_exp = hs && out_q[0].last;
        if (hs) void'(out_q.pop_front());
        if (acc) begin
            b = beats_q.pop_front();
            out_q.push_back(b.f);
            if (b.f.nw) open_pkt = !b.f.last;
            else if (b.f.last) open_pkt = 0;
        end
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n = 0;
        while ((beats_q.size() > 0 || out_q.size() > 0) && n < budget) begin
            if (rnd) step(($urandom % 4) != 0, ($urandom % 3) != 0);
            else step(1'b1, 1'b1);
            n++;
        end
        if (n >= budget) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d cycles required < %0d", n, budget);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [1:0]  vc;
        logic [7:0]  sz;
        logic        e_val, e_new, e_last;
        logic [1:0]  e_vc;
        logic [7:0]  e_sz;
        logic [31:0] e_d;
        logic        e_busy, e_done;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [31:0] d, input logic [1:0] vc, input logic [7:0] sz,
        input logic ev, input logic en, input logic el, input logic [1:0] evc,
        input logic [7:0] esz, input logic [31:0] ed, input logic eb, input logic edn);
        vec_t r;
        r.v = v; r.d = d; r.vc = vc; r.sz = sz;
        r.e_val = ev; r.e_new = en; r.e_last = el; r.e_vc = evc;
        r.e_sz = esz; r.e_d = ed; r.e_busy = eb; r.e_done = edn;
        return r;
    endfunction

    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resp1.ready = 1'b1;
        resp0.ready = 1'b1;

        tbl[0]  = mk(1, 32'h1111_0000, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h1111_0001, 3, 9, 1, 1, 0, 1, 4, 32'h1111_0000, 1, 0);
        tbl[2]  = mk(1, 32'h1111_0002, 0, 0, 1, 0, 0, 1, 4, 32'h1111_0001, 1, 0);
        tbl[3]  = mk(1, 32'h1111_0003, 2, 1, 1, 0, 0, 1, 4, 32'h1111_0002, 1, 0);
        tbl[4]  = mk(0, 32'h0, 0, 0, 1, 0, 1, 1, 4, 32'h1111_0003, 0, 0);
        tbl[5]  = mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, 32'h2222_0000, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 32'h3333_0000, 2, 3, 1, 1, 1, 2, 1, 32'h2222_0000, 0, 0);
        tbl[8]  = mk(1, 32'h3333_0001, 0, 5, 1, 1, 0, 2, 3, 32'h3333_0000, 1, 1);
        tbl[9]  = mk(1, 32'h3333_0002, 0, 0, 1, 0, 0, 2, 3, 32'h3333_0001, 1, 0);
        tbl[10] = mk(0, 32'h0, 0, 0, 1, 0, 1, 2, 3, 32'h3333_0002, 0, 0);
        tbl[11] = mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed table: 4-flit packet, 1-flit packet, back-to-back 3-flit packet
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("t%0d_valid", c), 64'(req1.valid), 64'(tbl[c].e_val));
            if (tbl[c].e_val) begin
                chk($sformatf("t%0d_new", c), 64'(req1.req_new), 64'(tbl[c].e_new));
                chk($sformatf("t%0d_last", c), 64'(req1.req_last), 64'(tbl[c].e_last));
                chk($sformatf("t%0d_vc", c), 64'(req1.vc_id), 64'(tbl[c].e_vc));
                chk($sformatf("t%0d_sz", c), 64'(req1.pkt_sz), 64'(tbl[c].e_sz));
                chk($sformatf("t%0d_data", c), 64'(req1.flit_data_width), 64'(tbl[c].e_d));
            end
            chk($sformatf("t%0d_busy", c), 64'(busy1), 64'(tbl[c].e_busy));
            chk($sformatf("t%0d_done", c), 64'(done1), 64'(tbl[c].e_done));
            chk($sformatf("t%0d_bready", c), 64'(brdy1), 64'(1));
            v1 = tbl[c].v; d1 = tbl[c].d; vc1 = tbl[c].vc; sz1 = tbl[c].sz;
            @(negedge clk);
        end
        v1 = 1'b0;

        // Downstream stall of 5 cycles during a 6-flit packet
        add_pkt(6, 2'd3);
        for (int c = 0; c < 12; c++) step(1'b1, !(c >= 2 && c < 7));
        drain(100, 1'b0);

        // Reset after 2 of 5 flits accepted
        add_pkt(5, 2'd2);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        v1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        beats_q.delete();
        out_q.delete();
        open_pkt = 0;
        done_exp = 0;
        chk("rst_valid", 64'(req1.valid), 64'(0));
        chk("rst_busy", 64'(busy1), 64'(0));
        chk("rst_bready", 64'(brdy1), 64'(1));
        chk("rst_done", 64'(done1), 64'(0));
        add_pkt(2, 2'd1);
        drain(50, 1'b0);

        // Longest legal packet
        add_pkt(255, 2'd0);
        drain(400, 1'b0);

        // Random packets with random valid and downstream ready
        for (int p = 0; p < 40; p++) add_pkt(int'($urandom_range(0, 9)), 2'($urandom));
        drain(3000, 1'b1);

        // Size taken from the head data field
        @(negedge clk);
        v0 = 1'b1; d0 = 32'h00AB_CDEF; vc0 = 2'd1; sz0 = 8'd7;
        @(negedge clk);
        v0 = 1'b0;
        chk("a0_valid", 64'(req0.valid), 64'(1));
        chk("a0_new", 64'(req0.req_new), 64'(1));
        chk("a0_last", 64'(req0.req_last), 64'(1));
        chk("a0_sz", 64'(req0.pkt_sz), 64'(1));
        chk("a0_busy", 64'(busy0), 64'(0));
        @(negedge clk);
        chk("a0_done", 64'(done0), 64'(1));
        v0 = 1'b1; d0 = 32'h0300_0011; vc0 = 2'd2; sz0 = 8'd1;
        @(negedge clk);
        d0 = 32'h0000_0022; vc0 = 2'd0;
        chk("a1_new", 64'(req0.req_new), 64'(1));
        chk("a1_last", 64'(req0.req_last), 64'(0));
        chk("a1_sz", 64'(req0.pkt_sz), 64'(3));
        chk("a1_busy", 64'(busy0), 64'(1));
        @(negedge clk);
        d0 = 32'h0000_0033;
        chk("a2_data", 64'(req0.flit_data_width), 64'(32'h0000_0022));
        chk("a2_vc", 64'(req0.vc_id), 64'(2));
        chk("a2_last", 64'(req0.req_last), 64'(0));
        @(negedge clk);
        v0 = 1'b0;
        chk("a3_last", 64'(req0.req_last), 64'(1));
        chk("a3_sz", 64'(req0.pkt_sz), 64'(3));
        chk("a3_busy", 64'(busy0), 64'(0));
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
